jpc_pc_seq: RTL
===============

# jpc_pc_seq

Parametrised program-counter sequencer, the successor to the fetch-stage PC register. It generates the fetch address every cycle from several sources in a fixed priority order: sequential increment, branch/jump redirect, trap entry, trap return, and a return-address stack (RAS) pop. It sits at the head of the fetch stage and drives the instruction-memory address and its valid qualifier.

## Interface
- `ADDR_W`, 32: PC width in bits. Must be a multiple of 8 when `BIG_END`=1.
- `STEP`, 4: sequential increment in bytes.
- `RESET_VEC`, 0: PC value loaded on reset.
- `TRAP_VEC`, 'h100: PC value loaded on trap entry.
- `RAS_DEPTH`, 4: number of return-address stack entries. Must be a power of two, ≥2.
- `BIG_END`, 0: when 1, `redirect_pc_I` is byte-reversed before use.

Ports:
- `clk` in 1: single clock. All state changes on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `stall_I` in 1: hold the PC.
- `redirect_valid_I` in 1: load the redirect target.
- `redirect_pc_I` in `ADDR_W`: redirect target.
- `trap_I` in 1: trap entry.
- `trap_return_I` in 1: return from trap.
- `call_I` in 1: the current `pc_O` is a call instruction; push the return address.
- `ret_I` in 1: the current `pc_O` is a return instruction; pop from the RAS.
- `pc_O` out `ADDR_W`: current fetch address.
- `pc_valid_O` out 1: `pc_O` is valid for fetch.
- `epc_O` out `ADDR_W`: saved exception PC.
- `ras_empty_O` out 1: RAS holds no entries.
- `ras_full_O` out 1: RAS holds `RAS_DEPTH` entries.
- `ras_err_O` out 1: sticky flag; set on RAS overflow or underflow.

## Operation
The next PC is selected by strict priority:
1. `rst`: load `RESET_VEC`.
2. `trap_I`: load `TRAP_VEC`; `epc_O` <= `pc_O`.
3. `trap_return_I`: load `epc_O`.
4. `redirect_valid_I`: load the target, byte-swapped when `BIG_END`=1.
5. `ret_I` with the RAS non-empty: load the RAS top.
6. `stall_I`: hold `pc_O`.
7. Otherwise: `pc_O` + `STEP`.

Sources 2–5 take effect even when `stall_I`=1.

Arithmetic:
- `pc_O` + `STEP` wraps modulo 2^`ADDR_W`. There is no carry-out and no alignment check.

RAS organisation and update rules:
- Circular buffer with a top pointer and a saturating count, 0..`RAS_DEPTH`.
- RAS updates are gated by the *accept* condition: `!stall_I && !trap_I && !trap_return_I`.
- Push (`call_I` accepted): write `pc_O` + `STEP`; count increments.
- Push when full: overwrite the oldest entry; count stays at `RAS_DEPTH`; set `ras_err_O`.
- Pop (`ret_I` accepted, non-empty): count decrements.
- Pop when empty (underflow): fall through to priority 6/7; RAS unchanged; set `ras_err_O`.
- `ret_I` together with `redirect_valid_I`: the redirect wins the PC, but the pop still occurs. This keeps the stack consistent with the executed return.
- `call_I` and `ret_I` together, non-empty: the next PC is the old top; the top is replaced with `pc_O` + `STEP`; count unchanged.
- `call_I` and `ret_I` together, empty: push only; `ras_err_O` is set.

`pc_valid_O`:
- 0 while `rst` is asserted, and 0 in the cycle immediately after trap entry, so a fetch issued in the trap cycle is squashed.
- 1 otherwise.

`ras_err_O` is cleared only by `rst`.

## Timing
- Single-cycle latency: the value chosen in cycle N appears on `pc_O` after edge N+1.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Reset values:
  - `pc_O`=`RESET_VEC`
  - `pc_valid_O`=0
  - `epc_O`=0
  - `ras_empty_O`=1
  - `ras_full_O`=0
  - `ras_err_O`=0
  - RAS count and pointer = 0
- `rst` asserted mid-operation overrides every other input in that cycle. RAS contents are not cleared, but count 0 makes them unreachable.
- A trap arriving while `trap_return_I` is also asserted: the trap wins, and `epc_O` takes the current `pc_O`.
- `ras_empty_O` and `ras_full_O` reflect the count after the edge, i.e. they are registered alongside it.

## Structure
- Package `jpc_pc_pkg` holds:
  - the `pc_src_t` enum: RESET, TRAP, TRET, REDIR, RAS, HOLD, SEQ;
  - the default `STEP`, `RESET_VEC` and `TRAP_VEC` constants;
  - a `bswap` function.
- Sub-module `jpc_ras` owns storage, pointer and count, with push/pop/replace strobes, and top/empty/full/overflow/underflow outputs.
- `jpc_pc_seq` contains the priority mux, the PC/EPC registers and the valid logic.

## Test plan
- Reset, then 3 free-running cycles: `pc_O` = 0, 4, 8, C; `pc_valid_O` = 0 during reset, 1 after.
- Stall for 2 cycles at PC 8, then `redirect_valid_I` with 'h40 while stalled: PC holds 8, 8, then becomes 'h40.
- `BIG_END`=1, redirect 'h11223344: `pc_O` = 'h44332211.
- Call at PC 'h10 with redirect 'h80, then `ret_I` at 'h84: PC sequence 'h10 → 'h80 → 'h84 → 'h14; RAS returns to empty.
- 5 calls with `RAS_DEPTH`=4: `ras_full_O`=1 and `ras_err_O`=1; 4 returns then yield the last 4 return addresses in LIFO order; a 5th `ret_I` falls through to `pc_O`+4.
- Trap at PC 'h20: `pc_O` = 'h100, `epc_O` = 'h20, `pc_valid_O` = 0 for one cycle; then `trap_return_I` loads `pc_O` = 'h20.

Source files
------------

// File: rtl/jpc_pc_pkg.sv
// rtl/jpc_pc_pkg.sv - shared types, defaults and helpers for the PC sequencer
package jpc_pc_pkg;

   typedef enum logic [2:0] {RESET, TRAP, TRET, REDIR, RAS, HOLD, SEQ} pc_src_t;

   localparam int          DEF_STEP      = 4;
   localparam logic [63:0] DEF_RESET_VEC = 64'h0;
   localparam logic [63:0] DEF_TRAP_VEC  = 64'h100;

   // Reverses the lowest nbytes bytes of v; works on up to 64-bit values.
   function automatic logic [63:0] bswap(input logic [63:0] v, input int nbytes);
      logic [63:0] r;
      r = '0;
      for (int i = 0; i < 8; i++) begin
         if (i < nbytes) r[8*i +: 8] = v[8*(nbytes-1-i) +: 8];
      end
      return r;
   endfunction

endpackage

// File: rtl/jpc_pc_seq_if.sv
// rtl/jpc_pc_seq_if.sv - control and status bundle of the PC sequencer
interface jpc_pc_seq_if #(parameter int ADDR_W = 32);

   logic              stall_I;
   logic              redirect_valid_I;
   logic [ADDR_W-1:0] redirect_pc_I;
   logic              trap_I;
   logic              trap_return_I;
   logic              call_I;
   logic              ret_I;
   logic [ADDR_W-1:0] pc_O;
   logic              pc_valid_O;
   logic [ADDR_W-1:0] epc_O;
   logic              ras_empty_O;
   logic              ras_full_O;
   logic              ras_err_O;

   modport master (
      output stall_I, redirect_valid_I, redirect_pc_I, trap_I, trap_return_I, call_I, ret_I,
      input  pc_O, pc_valid_O, epc_O, ras_empty_O, ras_full_O, ras_err_O
   );

   modport slave (
      input  stall_I, redirect_valid_I, redirect_pc_I, trap_I, trap_return_I, call_I, ret_I,
      output pc_O, pc_valid_O, epc_O, ras_empty_O, ras_full_O, ras_err_O
   );

endinterface

// File: rtl/jpc_ras.sv
// rtl/jpc_ras.sv - circular return-address stack with saturating count
module jpc_ras #(
   parameter int DEPTH = 4,
   parameter int W     = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic         pop,
   input  logic         replace,
   input  logic [W-1:0] din,
   output logic [W-1:0] top,
   output logic         empty,
   output logic         full,
   output logic         overflow,
   output logic         underflow
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   logic [W-1:0]  mem [DEPTH];
   logic [PW-1:0] ptr;
   logic [PW-1:0] ptr_m1;
   logic [CW-1:0] cnt;

   // ptr is the next free slot; when full it also addresses the oldest entry
   assign ptr_m1    = ptr - PW'(1);
   assign top       = mem[ptr_m1];
   assign empty     = (cnt == '0);
   assign full      = (cnt == CW'(DEPTH));
   assign overflow  = push && full;
   assign underflow = pop && empty;

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr <= '0;
         cnt <= '0;
      end else if (replace) begin
         ptr <= ptr;
      end else if (push) begin
         ptr <= ptr + PW'(1);
         if (!full) cnt <= cnt + CW'(1);
      end else if (pop && !empty) begin
         ptr <= ptr_m1;
         cnt <= cnt - CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (replace)   mem[ptr_m1] <= din;
      else if (push) mem[ptr]    <= din;
   end

endmodule

// File: rtl/jpc_pc_seq.sv
// rtl/jpc_pc_seq.sv - prioritised fetch PC sequencer with trap and RAS support
module jpc_pc_seq
   import jpc_pc_pkg::*;
#(
   parameter int          ADDR_W    = 32,
   parameter int          STEP      = DEF_STEP,
   parameter logic [63:0] RESET_VEC = DEF_RESET_VEC,
   parameter logic [63:0] TRAP_VEC  = DEF_TRAP_VEC,
   parameter int          RAS_DEPTH = 4,
   parameter bit          BIG_END   = 1'b0
) (
   input logic          clk,
   input logic          rst,
   jpc_pc_seq_if.slave  bus
);

   pc_src_t           src;
   logic [ADDR_W-1:0] pc_q, epc_q, nxt_pc, redir_pc, ras_top;
   logic              valid_q, err_q;
   logic              accept, ras_push, ras_pop, ras_replace;
   logic              ras_empty, ras_full, ras_ovf, ras_unf;

   assign redir_pc = BIG_END ? ADDR_W'(bswap(64'(bus.redirect_pc_I), ADDR_W / 8))
                             : bus.redirect_pc_I;

   // RAS only moves on cycles that actually retire the current PC
   assign accept      = !rst && !bus.stall_I && !bus.trap_I && !bus.trap_return_I;
   assign ras_replace = accept && bus.call_I && bus.ret_I && !ras_empty;
   assign ras_push    = accept && bus.call_I && !ras_replace;
   assign ras_pop     = accept && bus.ret_I && !ras_replace;

   always_comb begin
      src = SEQ;
      if (rst)                               src = RESET;
      else if (bus.trap_I)                   src = TRAP;
      else if (bus.trap_return_I)            src = TRET;
      else if (bus.redirect_valid_I)         src = REDIR;
      else if (bus.ret_I && !ras_empty)      src = RAS;
      else if (bus.stall_I)                  src = HOLD;
   end

   always_comb begin
      nxt_pc = pc_q + ADDR_W'(STEP);
      case (src)
         RESET:   nxt_pc = ADDR_W'(RESET_VEC);
         TRAP:    nxt_pc = ADDR_W'(TRAP_VEC);
         TRET:    nxt_pc = epc_q;
         REDIR:   nxt_pc = redir_pc;
         RAS:     nxt_pc = ras_top;
         HOLD:    nxt_pc = pc_q;
         default: nxt_pc = pc_q + ADDR_W'(STEP);
      endcase
   end

   always_ff @(posedge clk) begin
      pc_q <= nxt_pc;
      if (rst) begin
         valid_q <= 1'b0;
         epc_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         valid_q <= (src != TRAP);
         if (src == TRAP) epc_q <= pc_q;
         if (ras_ovf || ras_unf) err_q <= 1'b1;
      end
   end

   jpc_ras #(.DEPTH(RAS_DEPTH), .W(ADDR_W)) u_ras (
      .clk       (clk),
      .rst       (rst),
      .push      (ras_push),
      .pop       (ras_pop),
      .replace   (ras_replace),
      .din       (pc_q + ADDR_W'(STEP)),
      .top       (ras_top),
      .empty     (ras_empty),
      .full      (ras_full),
      .overflow  (ras_ovf),
      .underflow (ras_unf)
   );

   assign bus.pc_O        = pc_q;
   assign bus.pc_valid_O  = valid_q;
   assign bus.epc_O       = epc_q;
   assign bus.ras_empty_O = ras_empty;
   assign bus.ras_full_O  = ras_full;
   assign bus.ras_err_O   = err_q;

endmodule
